mul32_column_collector: RTL
===========================

// Module: mul32_column_collector
// PURPOSE
//   Consumer end of the mul32 column-sum interface. Each column stage emits three bytes per column k:
//   carry byte, sum-low byte and sum-high byte. This block accepts the columns k = 0..NUM_COLS-1 in order,
//   weights each one by 2^(8k), accumulates them and presents the final 64-bit product.
//   It sits after the column stages and before the mul32 result register and writeback.
// PARAMETERS
//   NUM_COLS   7   number of byte columns per product (0..6 for 32x32)
//   PROD_W     64  width of the product output
// PORTS
//   clk         in   1   single clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   begin a new product; sampled in IDLE only
//   in_valid    in   1   column beat valid
//   in_ready    out  1   collector accepts a beat this cycle
//   in_col      in   3   column index of the beat
//   in_lo       in   8   column sum bits [7:0]
//   in_hi       in   8   column sum bits [15:8]
//   in_cy       in   8   column sum bits [23:16] (carry byte)
//   prod_valid  out  1   product valid
//   prod_ready  in   1   downstream takes the product
//   product     out  64  accumulated product
//   err         out  1   sticky order error; cleared by start or rst
// BEHAVIOUR
//   Beat transfer: in_valid && in_ready on a rising clk edge. Product transfer: prod_valid && prod_ready.
//   Column value: colv = {in_cy, in_hi, in_lo} (24 bit).
//   Accumulation: acc[PROD_W+1:0] += colv << (8*beat_cnt). The 66-bit accumulator never wraps.
//     product = acc[63:0]; bits [65:64] are dropped.
//   FSM states:
//     IDLE    in_ready=0, prod_valid=0. start=1 -> clear acc, beat_cnt and err -> COLLECT.
//     COLLECT in_ready=1. Each accepted beat adds colv and increments beat_cnt.
//             The beat with beat_cnt==NUM_COLS-1 -> DONE.
//     DONE    in_ready=0, prod_valid=1, product held stable. prod_ready=1 -> IDLE.
//   Latency: prod_valid rises the cycle after the last beat is accepted.
//     Minimum start-to-product time is 1 + NUM_COLS cycles.
//   Cycles with in_valid=0 in COLLECT are stalls; the accumulator holds.
//   start asserted outside IDLE is ignored.
//   start and prod_ready in the same DONE cycle: go to IDLE only; start is not latched.
//   prod_valid never drops without a handshake.
//   Reset (including mid-product): state=IDLE, acc=0, beat_cnt=0, err=0,
//     in_ready=0, prod_valid=0, product=0. A partial product is discarded.
//   All outputs are registered, except in_ready, which is decoded from state.
// CONFIGURATION
//   COLLECTOR_ORDER_CHECK_EN defined:
//     An accepted beat with in_col != beat_cnt sets err=1, is not accumulated, and sends the FSM to DONE.
//     In DONE it presents product = 0 with prod_valid=1.
//   COLLECTOR_ORDER_CHECK_EN undefined:
//     in_col is ignored, the weight comes from beat_cnt only, and err is tied to 0.
// STRUCTURE
//   Package mul32_pkg:
//     collector state enum {IDLE, COLLECT, DONE};
//     MUL32_NUM_COLS = 7;
//     MUL32_COL_W = 24.
//   One sub-module, mul32_col_shift_add: combinational acc_next = acc + (colv << 8*idx).
//   FSM, counter and output registers stay in the top.
// TESTING
//   1. rst, start, beats k=0..6 with colv = n_k*0xFE01, n = {1,2,3,4,3,2,1}
//      -> product 0xFFFFFFFE00000001, prod_valid on cycle 9.
//   2. 0x12345678 * 0x00000001 columns (0x78,0x56,0x34,0x12,0,0,0)
//      -> product 0x0000000012345678, err=0.
//   3. Same as 1 with in_valid low on beats 2 and 5 for 3 cycles each
//      -> identical product, prod_valid 6 cycles later.
//   4. prod_ready held low 10 cycles in DONE -> product stable, in_ready=0;
//      a new start is ignored until the handshake.
//   5. rst pulsed after beat 3 -> all outputs 0 the same cycle;
//      a fresh start then test 2 -> 0x12345678.
//   6. ORDER_CHECK_EN: beat 2 sent with in_col=4 -> err=1, prod_valid=1, product=0;
//      the next start clears err.

Source files
------------

// File: rtl/mul32_pkg.sv
// Shared types and constants for the mul32 column-sum datapath.
// Collector state encoding plus column and product geometry.
package mul32_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } coll_state_e;

  localparam int MUL32_NUM_COLS = 7;
  localparam int MUL32_COL_W    = 24;
  localparam int MUL32_PROD_W   = 64;

endpackage

// File: rtl/mul32_column_collector_if.sv
// Column-beat and product handshake bundle of the mul32 collector.
// slave = collector side, master = column stage / writeback side.
interface mul32_column_collector_if;
  import mul32_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              in_col;
  logic [7:0]              in_lo;
  logic [7:0]              in_hi;
  logic [7:0]              in_cy;
  logic                    prod_valid;
  logic                    prod_ready;
  logic [MUL32_PROD_W-1:0] product;
  logic                    err;

  modport master (
    output in_valid, in_col, in_lo, in_hi, in_cy, prod_ready,
    input  in_ready, prod_valid, product, err
  );

  modport slave (
    input  in_valid, in_col, in_lo, in_hi, in_cy, prod_ready,
    output in_ready, prod_valid, product, err
  );

endinterface

// File: rtl/mul32_col_shift_add.sv
// Combinational column weighting: acc_next = acc + (colv << 8*idx).
// The term is sized to the accumulator so it cannot wrap early.
module mul32_col_shift_add
  import mul32_pkg::*;
#(
  parameter int ACC_W = MUL32_PROD_W + 2
) (
  input  logic [ACC_W-1:0]       acc,
  input  logic [MUL32_COL_W-1:0] colv,
  input  logic [2:0]             idx,
  output logic [ACC_W-1:0]       acc_next
);

  logic [ACC_W-1:0] term;

  always_comb begin
    term     = ACC_W'(colv) << {idx, 3'b000};
    acc_next = acc + term;
  end

endmodule

// File: rtl/mul32_column_collector.sv
// Collects the byte-weighted column sums of a 32x32 product into 64 bits.
// Optional column-order checking: COLLECTOR_ORDER_CHECK_EN.
module mul32_column_collector
  import mul32_pkg::*;
#(
  parameter int NUM_COLS = MUL32_NUM_COLS,
  parameter int PROD_W   = MUL32_PROD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  mul32_column_collector_if.slave  bus
);

  localparam int         ACC_W = PROD_W + 2;
  localparam logic [2:0] LAST  = 3'(NUM_COLS - 1);

  coll_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_next;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              pv_q, pv_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [23:0]       colv;
  logic              ord_err;

  assign colv = {bus.in_cy, bus.in_hi, bus.in_lo};

`ifdef COLLECTOR_ORDER_CHECK_EN
  assign ord_err = (bus.in_col != cnt_q);
`else
  assign ord_err = 1'b0;
`endif

  mul32_col_shift_add #(.ACC_W(ACC_W)) u_sa (
    .acc      (acc_q),
    .colv     (colv),
    .idx      (cnt_q),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pv_d    = pv_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          if (ord_err) begin
            // out-of-order beat: abort with a zero product
            err_d   = 1'b1;
            prod_d  = '0;
            pv_d    = 1'b1;
            state_d = DONE;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
              prod_d  = acc_next[PROD_W-1:0];
              pv_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (bus.prod_ready) begin
          pv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pv_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready   = (state_q == COLLECT);
  assign bus.prod_valid = pv_q;
  assign bus.product    = prod_q;
  assign bus.err        = err_q;

endmodule
